// File: rtl/axilite_aes_key_regs_if.sv
// AXI4-Lite bus bundle for the AES key register block.
// The master modport is the PS side; the slave modport is the register block.
interface axilite_aes_key_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axilite_aes_key_regs.sv
// AXI4-Lite slave holding a 128-bit AES key in KEY0..KEY3 plus CTRL/STATUS,
// pushing a frozen key snapshot to the AES core over valid/ready.
module axilite_aes_key_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESET,
  axilite_aes_key_regs_if.slave  s_axi,
  output logic [127:0]           key_out,
  output logic                   key_valid,
  input  logic                   key_ready
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int         DW     = C_S_AXI_DATA_WIDTH;

  logic          r_init;
  logic          r_aw_vld, r_w_vld, r_bvalid, r_rvalid;
  logic [2:0]    r_awidx;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_bresp, r_rresp;
  logic [31:0]   r_key [4];
  logic          r_loaded, r_overrun, r_key_valid;
  logic [127:0]  r_key_out;

  logic          w_awready, w_wready, w_arready, w_commit, w_load, w_ovr_clr;
  logic [2:0]    w_aridx;
  logic [DW-1:0] w_rd_data;
  logic [1:0]    w_rd_resp;
  logic [31:0]   w_status;
  logic          w_unused;

  // r_init holds the READY outputs low until the first cycle after reset.
  assign w_awready = r_init & ~r_aw_vld & ~r_bvalid;
  assign w_wready  = r_init & ~r_w_vld & ~r_bvalid;
  assign w_arready = r_init & ~r_rvalid;
  assign w_commit  = r_aw_vld & r_w_vld & ~r_bvalid;
  assign w_load    = w_commit && (r_awidx == 3'd4) && r_wstrb[0] && r_wdata[0];
  assign w_ovr_clr = w_commit && (r_awidx == 3'd5) && r_wstrb[0] && r_wdata[2];
  assign w_aridx   = s_axi.S_AXI_ARADDR[4:2];
  assign w_status  = {29'd0, r_overrun, r_loaded, r_key_valid};
  assign w_unused  = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign key_out             = r_key_out;
  assign key_valid           = r_key_valid;

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = OKAY;
    case (w_aridx)
      3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_key[w_aridx[1:0]];
      3'd5:                   w_rd_data = w_status;
      3'd6, 3'd7:             w_rd_resp = SLVERR;
      default:                w_rd_data = '0;
    endcase
  end

  // Write channel: AW and W latch independently, commit once both are held.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_init   <= 1'b0;
      r_aw_vld <= 1'b0;
      r_w_vld  <= 1'b0;
      r_awidx  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= OKAY;
    end else begin
      r_init <= 1'b1;
      if (s_axi.S_AXI_AWVALID && w_awready) begin
        r_aw_vld <= 1'b1;
        r_awidx  <= s_axi.S_AXI_AWADDR[4:2];
      end
      if (s_axi.S_AXI_WVALID && w_wready) begin
        r_w_vld <= 1'b1;
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (r_awidx[2:1] == 2'b11) ? SLVERR : OKAY;
      end else if (r_bvalid && s_axi.S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
        r_aw_vld <= 1'b0;
        r_w_vld  <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
        r_key[k] <= '0;
      end else if (w_commit && (r_awidx == 3'(k))) begin
        for (int b = 0; b < 4; b++)
          if (r_wstrb[b]) r_key[k][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  // Snapshot uses pre-edge KEYn; a LOAD while busy only flags OVERRUN.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_loaded    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load && !r_key_valid) begin
        r_key_out   <= {r_key[0], r_key[1], r_key[2], r_key[3]};
        r_key_valid <= 1'b1;
      end else if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
        r_loaded    <= 1'b1;
      end
      if (w_load && r_key_valid) r_overrun <= 1'b1;
      else if (w_ovr_clr)        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (s_axi.S_AXI_ARVALID && w_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid && s_axi.S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axilite_aes_key_regs.sv
// Scoreboarded bench for axilite_aes_key_regs: directed plan plus randomized
// traffic against a register-map reference model.
module tb_axilite_aes_key_regs;
  logic gclk = 1'b0;
  logic grst = 1'b1;
  logic [127:0] key_out;
  logic key_valid;
  logic key_ready = 1'b0;
  int checks = 0, passed = 0;

  always #5 gclk = ~gclk;

  axilite_aes_key_regs_if axi ();

  axilite_aes_key_regs dut (
    .S_AXI_ACLK(gclk), .S_AXI_ARESET(grst), .s_axi(axi),
    .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready)
  );

  // reference model state
  logic [31:0]  m_key [4];
  bit           m_kv, m_loaded, m_ovr;
  logic [127:0] m_kout;
  logic [1:0]   bq [$];
  logic [33:0]  rq [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    checks++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_key[i] = '0;
    m_kv = 0; m_loaded = 0; m_ovr = 0; m_kout = '0;
  endtask

  function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx = int'(a[4:2]);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_key[idx][8*b +: 8] = d[8*b +: 8];
    end else if (idx == 4) begin
      if (s[0] && d[0]) begin
        if (m_kv) m_ovr = 1;
        else begin
          m_kout = {m_key[0], m_key[1], m_key[2], m_key[3]};
          if (key_ready) m_loaded = 1; else m_kv = 1;
        end
      end
    end else if (idx == 5) begin
      if (s[0] && d[2]) m_ovr = 0;
    end else return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [4:0] a);
    int idx = int'(a[4:2]);
    if (idx < 4)  return {2'b00, m_key[idx]};
    if (idx == 5) return {2'b00, 29'd0, m_ovr, m_loaded, m_kv};
    if (idx == 4) return 34'd0;
    return {2'b10, 32'd0};
  endfunction

  // monitor: pops expected responses at each B/R handshake
  always @(negedge gclk) begin
    if (!grst) begin
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
        if (bq.size() == 0) begin
          checks++; $display("FAIL b_unexpected: got BVALID expected none");
        end else chk("bresp", axi.S_AXI_BRESP, bq.pop_front());
      end
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
        if (rq.size() == 0) begin
          checks++; $display("FAIL r_unexpected: got RVALID expected none");
        end else chk("rresp_rdata", {axi.S_AXI_RRESP, axi.S_AXI_RDATA}, rq.pop_front());
      end
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got;
    int n = 0;
    bq.push_back(model_write(a, d, s));
    axi.S_AXI_AWADDR = a; axi.S_AXI_WDATA = d; axi.S_AXI_WSTRB = s;
    axi.S_AXI_AWPROT = 3'($urandom);
    while (!(aw_done && w_done) && n < 64) begin
      axi.S_AXI_AWVALID = !aw_done && n >= awd;
      axi.S_AXI_WVALID  = !w_done && n >= wd;
      @(negedge gclk);
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge gclk); #1;
      aw_done |= aw_hs; w_done |= w_hs; n++;
    end
    axi.S_AXI_AWVALID = 0; axi.S_AXI_WVALID = 0;
    if (!(aw_done && w_done)) fail("aw_w_timeout");
    repeat (bd) begin @(posedge gclk); #1; end
    if (bd >= 2) begin
      @(negedge gclk);
      chk("b_held_aw_blocked", {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 3'b100);
      @(posedge gclk); #1;
    end
    axi.S_AXI_BREADY = 1; n = 0;
    do begin
      @(negedge gclk); got = axi.S_AXI_BVALID;
      @(posedge gclk); #1; n++;
    end while (!got && n < 32);
    axi.S_AXI_BREADY = 0;
    if (!got) fail("b_timeout");
  endtask

  task automatic axi_read(input logic [4:0] a, input int rd);
    bit got; int n = 0;
    rq.push_back(model_read(a));
    axi.S_AXI_ARADDR = a; axi.S_AXI_ARPROT = 3'($urandom); axi.S_AXI_ARVALID = 1;
    do begin
      @(negedge gclk); got = axi.S_AXI_ARREADY;
      @(posedge gclk); #1; n++;
    end while (!got && n < 32);
    axi.S_AXI_ARVALID = 0;
    if (!got) fail("ar_timeout");
    repeat (rd) begin @(posedge gclk); #1; end
    axi.S_AXI_RREADY = 1; n = 0;
    do begin
      @(negedge gclk); got = axi.S_AXI_RVALID;
      @(posedge gclk); #1; n++;
    end while (!got && n < 32);
    axi.S_AXI_RREADY = 0;
    if (!got) fail("r_timeout");
  endtask

  task automatic chk_key(input string nm);
    @(negedge gclk);
    chk({nm, "_valid"}, key_valid, m_kv);
    chk({nm, "_out"}, key_out, m_kout);
    @(posedge gclk); #1;
  endtask

  task automatic set_kr(input bit v);
    key_ready = v;
    repeat (2) begin @(posedge gclk); #1; end
    if (v && m_kv) begin m_kv = 0; m_loaded = 1; end
  endtask

  task automatic do_reset(input int n);
    grst = 1;
    repeat (n) begin @(posedge gclk); #1; end
    @(negedge gclk);
    chk("rst_axi_outs", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
        axi.S_AXI_ARREADY, axi.S_AXI_RVALID, axi.S_AXI_BRESP, axi.S_AXI_RRESP,
        axi.S_AXI_RDATA}, 0);
    chk("rst_key_outs", {key_valid, key_out}, 0);
    @(posedge gclk); #1;
    grst = 0;
    model_reset(); bq.delete(); rq.delete();
    @(posedge gclk); #1;
    @(negedge gclk);
    chk("ready_after_rst", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);
    @(posedge gclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] kv [4];
    axi.S_AXI_AWADDR = 0; axi.S_AXI_AWPROT = 0; axi.S_AXI_AWVALID = 0;
    axi.S_AXI_WDATA = 0; axi.S_AXI_WSTRB = 0; axi.S_AXI_WVALID = 0; axi.S_AXI_BREADY = 0;
    axi.S_AXI_ARADDR = 0; axi.S_AXI_ARPROT = 0; axi.S_AXI_ARVALID = 0; axi.S_AXI_RREADY = 0;
    model_reset();
    do_reset(3);

    // basic write / read-back
    for (int i = 0; i < 4; i++) axi_write(5'(4*i), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(5'(4*i), i % 2);

    // byte strobes
    axi_write(5'h04, 32'h0, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 1);
    axi_read(5'h04, 0);

    // AW/W skew with BREADY held off
    axi_write(5'h08, 32'h5555AAAA, 4'hF, 0, 3, 4);
    axi_write(5'h0C, 32'h12345678, 4'hF, 3, 0, 4);
    axi_read(5'h08, 2);
    axi_read(5'h0C, 0);

    // key push, overrun, handshake, W1C
    kv[0] = 32'h00112233; kv[1] = 32'h44556677; kv[2] = 32'h8899AABB; kv[3] = 32'hCCDDEEFF;
    for (int i = 0; i < 4; i++) axi_write(5'(4*i), kv[i], 4'hF, 0, 0, 0);
    axi_write(5'h10, 32'h1, 4'h1, 0, 0, 0);
    chk_key("load1");
    axi_read(5'h14, 0);
    axi_write(5'h10, 32'h1, 4'hF, 1, 0, 0);
    axi_read(5'h14, 0);
    axi_write(5'h00, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk_key("frozen");
    set_kr(1);
    chk_key("accepted");
    axi_read(5'h14, 1);
    axi_write(5'h14, 32'h4, 4'h1, 0, 0, 0);
    axi_read(5'h14, 0);
    axi_read(5'h00, 0);
    set_kr(0);

    // unmapped space
    axi_write(5'h18, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(5'h18, 0);
    axi_read(5'h1D, 0);
    axi_read(5'h00, 0);
    axi_read(5'h14, 0);

    // randomized traffic with key_ready tied high
    key_ready = 1;
    for (int t = 0; t < 80; t++) begin
      logic [4:0] a = 5'($urandom);
      logic [31:0] d = $urandom;
      logic [3:0] s = 4'($urandom);
      if ($urandom_range(1, 0) == 1)
        axi_write(a, d, s, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
      else
        axi_read(a, $urandom_range(3, 0));
    end
    for (int i = 0; i < 6; i++) axi_read(5'(4*i), 0);
    chk_key("random_end");

    // reset with a latched AW and a pending key
    key_ready = 0;
    axi_write(5'h10, 32'h1, 4'h1, 0, 0, 0);
    chk_key("pre_rst");
    axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_AWVALID = 1;
    @(posedge gclk); #1;
    axi.S_AXI_AWVALID = 0;
    @(negedge gclk);
    chk("aw_latched", axi.S_AXI_AWREADY, 1'b0);
    @(posedge gclk); #1;
    do_reset(2);
    for (int i = 0; i < 6; i++) axi_read(5'(4*i), 0);
    axi_write(5'h04, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    axi_read(5'h04, 0);
    axi_read(5'h00, 0);

    repeat (4) begin @(posedge gclk); #1; end
    chk("scoreboard_drained", 32'(bq.size() + rq.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axilite_aes_key_regs.md
Name: axilite_aes_key_regs

Overview:
AXI4-Lite slave (responder) that holds the 128-bit AES key programmed by the PS/master over four 32-bit registers. It adds a control/status pair and hands a snapshot of the key to the AES core over a valid/ready handshake. It is the slave end of the AXI4-Lite master traffic that writes KEY0..KEY3 and reads them back.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decode uses ADDR[4:2], and ADDR[1:0] is ignored.

Ports:
S_AXI_ACLK  in  1  single clock.
S_AXI_ARESET  in  1  reset, synchronous, active-high.
S_AXI_AWADDR  in  5  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write-response handshake.
S_AXI_ARADDR  in  5  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID/S_AXI_RREADY  out/in  1  read-data handshake.
key_out  out  128  key snapshot; KEY0 maps to [127:96], KEY3 maps to [31:0].
key_valid  out  1  key_out is valid.
key_ready  in  1  AES core accepts the key.

Behaviour:
- Register map:
  - 0x00..0x0C KEY0..KEY3: read/write.
  - 0x10 CTRL: bit0 LOAD, write-only, self-clearing, reads 0.
  - 0x14 STATUS: bit0 BUSY (=key_valid), RO; bit1 LOADED, RO; bit2 OVERRUN, write-1-to-clear; all other bits read 0.
  - 0x18, 0x1C: unmapped.
- Reset (synchronous, S_AXI_ARESET=1 at a rising edge):
  - All READY/VALID outputs are 0; BRESP/RRESP/RDATA are 0.
  - KEY0..3, STATUS, key_out and key_valid are 0.
  - Any in-flight AW/W/AR is dropped. AWREADY/WREADY/ARREADY rise the first cycle after reset deasserts.
- Write channel:
  - AW and W are accepted independently, in either order or together, and each is latched.
  - AWREADY is high only while no AW is latched and BVALID=0. The same rule applies to WREADY with W. This gives one outstanding write.
  - Register update happens in the cycle after both AW and W are latched. BVALID rises in that same cycle.
  - BRESP=OKAY for mapped addresses, SLVERR for unmapped (no state change).
  - BVALID holds until BREADY; the latches clear on the B handshake.
- WSTRB: only strobed bytes of KEYn are updated. WSTRB[0] gates CTRL.LOAD and STATUS.OVERRUN clear.
- Read channel:
  - ARREADY is high while RVALID=0.
  - RVALID and RDATA are registered the cycle after the AR handshake. RDATA is sampled from pre-edge register values, so a write committing in the same cycle is not visible.
  - RDATA/RRESP are held stable until RREADY. Unmapped addresses return RDATA=0, RRESP=SLVERR.
- Key push:
  - A LOAD write with key_valid=0 copies {KEY0,KEY1,KEY2,KEY3} into key_out and sets key_valid on the same edge as the register update.
  - key_valid holds until key_valid&&key_ready. It then clears on that edge and LOADED is set (sticky until reset).
  - A LOAD while key_valid=1 is ignored, sets OVERRUN, and key_out is unchanged.
  - KEYn writes while busy update the registers only; key_out stays frozen.
  - key_ready may be permanently high; minimum key_valid width is 1 cycle.
  - Simultaneous OVERRUN set and W1C clear: set wins.
- Latency: write takes ≥2 cycles from handshake to BVALID when AW/W arrive together; read takes 1 cycle from AR handshake to RVALID.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00..0x0C, then read back the same addresses → RDATA 0x1..0x4, all BRESP/RRESP=OKAY.
- Write WDATA 0xAABBCCDD with WSTRB=0b0101 to KEY1 after 0 → read 0x00BB00DD.
- AW issued 3 cycles before W, then W before AW, with BREADY low for 4 cycles → single write each, BVALID held, AWREADY low until the B handshake.
- Keys 0x00112233/44556677/8899AABB/CCDDEEFF, write CTRL=1 with key_ready=0 → key_out=0x00112233_44556677_8899AABB_CCDDEEFF, key_valid=1, STATUS=0x1. Second LOAD → STATUS=0x5. Raise key_ready → key_valid=0, STATUS=0x6. Write STATUS=0x4 → STATUS=0x2.
- Read/write 0x18 → RRESP/BRESP=SLVERR, RDATA=0, no state change.
- Assert reset mid-write (AW latched, W pending) and with key_valid=1 → all outputs 0, KEYn read 0 afterwards.
